// File: rtl/gcd_binary_core.sv
// gcd_binary_core: binary (Stein) GCD engine built from shifts and subtractions only.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   abort      synchronous abort; drops any job in flight and clears result/cycles
//   in_valid   operand pair valid
//   in_ready   core can accept operands (idle and not aborting)
//   opa, opb   operands, sampled only on the accept cycle
//   out_valid  result valid; held until out_ready
//   out_ready  sink accepts result
//   result     gcd(opa, opb); gcd(x, 0) = x, gcd(0, 0) = 0
//   coprime    result == 1
//   cycles     cycles spent in STRIP + ODD for this job, saturating

module gcd_binary_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             coprime,
   output logic [CNT_W-1:0] cycles
);

   localparam int unsigned KW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StStrip, StOdd, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W-1:0] cycles_inc;

   // Saturate rather than wrap so long jobs still report a meaningful lower bound.
   assign cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      k_d      = k_q;
      result_d = result_q;
      cycles_d = cycles_q;
      if (abort) begin
         state_d  = StIdle;
         a_d      = '0;
         b_d      = '0;
         k_d      = '0;
         result_d = '0;
         cycles_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_d      = opa;
                  b_d      = opb;
                  k_d      = '0;
                  cycles_d = '0;
                  if (opa == '0 || opb == '0) begin
                     // One side is zero: the other operand is the answer.
                     result_d = opa | opb;
                     state_d  = StDone;
                  end else begin
                     state_d = StStrip;
                  end
               end
            end
            StStrip: begin
               cycles_d = cycles_inc;
               // Remove common factors of two; k remembers how many to restore.
               if (!a_q[0] && !b_q[0]) begin
                  a_d = a_q >> 1;
                  b_d = b_q >> 1;
                  k_d = k_q + KW'(1);
               end else begin
                  state_d = StOdd;
               end
            end
            StOdd: begin
               cycles_d = cycles_inc;
               if (!a_q[0]) begin
                  a_d = a_q >> 1;
               end else if (!b_q[0]) begin
                  b_d = b_q >> 1;
               end else if (a_q == b_q) begin
                  result_d = a_q << k_q;
                  state_d  = StDone;
               end else if (a_q > b_q) begin
                  a_d = a_q - b_q;
               end else begin
                  b_d = b_q - a_q;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         k_q      <= '0;
         result_q <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         k_q      <= k_d;
         result_q <= result_d;
         cycles_q <= cycles_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !abort;
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign coprime   = (result_q == WIDTH'(1));
   assign cycles    = cycles_q;

endmodule
